// File: rtl/regfile_sb_if.sv
// Bus bundle for regfile_sb: write port, two read ports, busy scoreboard.
// The master drives selects and strobes; the slave returns read data and busy status.
interface regfile_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              reg_write;
    logic [ADDR_W-1:0] w_reg0;
    logic [DATA_W-1:0] w_data;
    logic [ADDR_W-1:0] r_reg0;
    logic [ADDR_W-1:0] r_reg1;
    logic [DATA_W-1:0] reg0;
    logic [DATA_W-1:0] reg1;
    logic              busy_set;
    logic [ADDR_W-1:0] busy_reg;
    logic              busy0;
    logic              busy1;
    logic [ADDR_W:0]   pend_cnt;

    modport master (
        output reg_write, w_reg0, w_data, r_reg0, r_reg1, busy_set, busy_reg,
        input  reg0, reg1, busy0, busy1, pend_cnt
    );

    modport slave (
        input  reg_write, w_reg0, w_data, r_reg0, r_reg1, busy_set, busy_reg,
        output reg0, reg1, busy0, busy1, pend_cnt
    );
endinterface

// File: rtl/regfile_sb.sv
// Register file with two combinational read ports, one write port and a
// per-register busy scoreboard with a running count of pending registers.
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input logic         clk,
    input logic         reset_n,
    regfile_sb_if.slave bus
);
    localparam int              DEPTH   = 2 ** ADDR_W;
    localparam bit              ZR      = (ZERO_REG != 0);
    localparam bit              BP      = (BYPASS != 0);
    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W + 1)'(1);

    logic [DEPTH-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [DEPTH-1:0]             busy_q, busy_d;
    logic [ADDR_W:0]              pend_cnt_q, pend_cnt_d;
    logic                         wr_ok, set_ok, set_new, clr_eff;
    logic [DATA_W-1:0]            rd0, rd1;

    // A set wins over a clear on the same register, so the count only moves
    // when exactly one of "new set" and "effective clear" happens.
    always_comb begin
        wr_ok   = bus.reg_write && !(ZR && bus.w_reg0 == '0);
        set_ok  = bus.busy_set && !(ZR && bus.busy_reg == '0);
        set_new = set_ok && !busy_q[bus.busy_reg];
        clr_eff = wr_ok && busy_q[bus.w_reg0]
                  && !(set_ok && bus.busy_reg == bus.w_reg0);

        regs_d = regs_q;
        busy_d = busy_q;
        if (wr_ok) begin
            regs_d[bus.w_reg0] = bus.w_data;
            busy_d[bus.w_reg0] = 1'b0;
        end
        if (set_ok) begin
            busy_d[bus.busy_reg] = 1'b1;
        end

        pend_cnt_d = pend_cnt_q;
        if (set_new && !clr_eff) begin
            pend_cnt_d = pend_cnt_q + CNT_ONE;
        end else if (clr_eff && !set_new) begin
            pend_cnt_d = pend_cnt_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            regs_q     <= '0;
            busy_q     <= '0;
            pend_cnt_q <= '0;
        end else begin
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end

    // Register 0 reads as zero even if a write to it is being presented.
    always_comb begin
        rd0 = regs_q[bus.r_reg0];
        rd1 = regs_q[bus.r_reg1];
        if (BP && bus.reg_write && bus.w_reg0 == bus.r_reg0) begin
            rd0 = bus.w_data;
        end
        if (BP && bus.reg_write && bus.w_reg0 == bus.r_reg1) begin
            rd1 = bus.w_data;
        end
        if (ZR && bus.r_reg0 == '0) begin
            rd0 = '0;
        end
        if (ZR && bus.r_reg1 == '0) begin
            rd1 = '0;
        end
    end

    assign bus.reg0     = rd0;
    assign bus.reg1     = rd1;
    assign bus.busy0    = busy_q[bus.r_reg0];
    assign bus.busy1    = busy_q[bus.r_reg1];
    assign bus.pend_cnt = pend_cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: two instances (zero-reg+bypass, plain+no-bypass)
// share one stimulus stream and are checked every cycle against a behavioural model.
module tb_regfile_sb;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        we = 1'b0;
    logic [4:0]  wr = '0;
    logic [31:0] wd = '0;
    logic [4:0]  rs0 = '0;
    logic [4:0]  rs1 = '0;
    logic        bs = 1'b0;
    logic [4:0]  br = '0;
    logic        running = 1'b0;
    int          total = 0;
    int          bad = 0;

    logic [31:0] mregs [2][32];
    bit          mbusy [2][32];

    logic [31:0] o_reg0 [2];
    logic [31:0] o_reg1 [2];
    logic        o_busy0 [2];
    logic        o_busy1 [2];
    logic [5:0]  o_pend [2];

    always #5 clk = ~clk;

    regfile_sb_if #(.DATA_W(32), .ADDR_W(5)) ifa ();
    regfile_sb_if #(.DATA_W(32), .ADDR_W(5)) ifb ();

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(ifa.slave));
    regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(ifb.slave));

    assign ifa.reg_write = we;
    assign ifa.w_reg0    = wr;
    assign ifa.w_data    = wd;
    assign ifa.r_reg0    = rs0;
    assign ifa.r_reg1    = rs1;
    assign ifa.busy_set  = bs;
    assign ifa.busy_reg  = br;
    assign ifb.reg_write = we;
    assign ifb.w_reg0    = wr;
    assign ifb.w_data    = wd;
    assign ifb.r_reg0    = rs0;
    assign ifb.r_reg1    = rs1;
    assign ifb.busy_set  = bs;
    assign ifb.busy_reg  = br;

    assign o_reg0[0]  = ifa.reg0;
    assign o_reg1[0]  = ifa.reg1;
    assign o_busy0[0] = ifa.busy0;
    assign o_busy1[0] = ifa.busy1;
    assign o_pend[0]  = ifa.pend_cnt;
    assign o_reg0[1]  = ifb.reg0;
    assign o_reg1[1]  = ifb.reg1;
    assign o_busy0[1] = ifb.busy0;
    assign o_busy1[1] = ifb.busy1;
    assign o_pend[1]  = ifb.pend_cnt;

    // Instance 0 has a hardwired zero register and bypass; instance 1 has neither.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 2; k++)
                for (int i = 0; i < 32; i++) begin
                    mregs[k][i] = '0;
                    mbusy[k][i] = 1'b0;
                end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (we && !(k == 0 && wr == 0)) begin
                    mregs[k][wr] = wd;
                    mbusy[k][wr] = 1'b0;
                end
                if (bs && !(k == 0 && br == 0))
                    mbusy[k][br] = 1'b1;
            end
        end
    end

    function automatic logic [31:0] expRead(int k, logic [4:0] sel);
        if (k == 0 && sel == 0) return 32'h0;
        if (k == 0 && we && wr == sel) return wd;
        return mregs[k][sel];
    endfunction

    function automatic logic [31:0] expPend(int k);
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(mbusy[k][i]);
        return 32'(n);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (running) begin
            for (int k = 0; k < 2; k++) begin
                checkOutput($sformatf("m%0d.reg0", k), o_reg0[k], expRead(k, rs0));
                checkOutput($sformatf("m%0d.reg1", k), o_reg1[k], expRead(k, rs1));
                checkOutput($sformatf("m%0d.busy0", k), 32'(o_busy0[k]), 32'(mbusy[k][rs0]));
                checkOutput($sformatf("m%0d.busy1", k), 32'(o_busy1[k]), 32'(mbusy[k][rs1]));
                checkOutput($sformatf("m%0d.pend", k), 32'(o_pend[k]), expPend(k));
            end
        end
    end

    // Inputs change just after a rising edge and are held until the next one.
    task automatic applyStimulus(input logic i_we, input logic [4:0] i_wr,
                                 input logic [31:0] i_wd, input logic [4:0] i_r0,
                                 input logic [4:0] i_r1, input logic i_bs,
                                 input logic [4:0] i_br);
        @(posedge clk);
        #1;
        we = i_we; wr = i_wr; wd = i_wd;
        rs0 = i_r0; rs1 = i_r1; bs = i_bs; br = i_br;
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input logic [4:0] i_r0, input logic [4:0] i_r1);
        applyStimulus(1'b0, 5'd0, 32'h0, i_r0, i_r1, 1'b0, 5'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        #7 running = 1'b1;
        #5;
        checkOutput("rst.reg0", ifa.reg0, 32'h0);
        checkOutput("rst.pend", 32'(ifb.pend_cnt), 32'h0);
        #10 reset_n = 1'b1;

        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 1'b0, 5'd0);
        checkOutput("byp.a.r5", ifa.reg0, 32'hDEADBEEF);
        checkOutput("nobyp.b.r5", ifb.reg0, 32'h0);
        idle(5'd5, 5'd0);
        checkOutput("rd.a.r5", ifa.reg0, 32'hDEADBEEF);
        checkOutput("rd.a.r0", ifa.reg1, 32'h0);
        checkOutput("rd.b.r5", ifb.reg0, 32'hDEADBEEF);

        applyStimulus(1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0, 1'b0, 5'd0);
        idle(5'd0, 5'd0);
        checkOutput("zr.a.reg0", ifa.reg0, 32'h0);
        checkOutput("zr.a.busy0", 32'(ifa.busy0), 32'h0);
        checkOutput("nozr.b.reg0", ifb.reg0, 32'h12345678);

        applyStimulus(1'b1, 5'd7, 32'h1, 5'd0, 5'd7, 1'b0, 5'd0);
        applyStimulus(1'b1, 5'd7, 32'h2, 5'd0, 5'd7, 1'b0, 5'd0);
        checkOutput("byp.a.r7", ifa.reg1, 32'h2);
        checkOutput("old.b.r7", ifb.reg1, 32'h1);
        idle(5'd0, 5'd7);
        checkOutput("new.b.r7", ifb.reg1, 32'h2);

        applyStimulus(1'b0, 5'd0, 32'h0, 5'd3, 5'd4, 1'b1, 5'd3);
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd3, 5'd4, 1'b1, 5'd4);
        idle(5'd3, 5'd4);
        checkOutput("sb.pend2", 32'(ifa.pend_cnt), 32'd2);
        checkOutput("sb.busy3", 32'(ifa.busy0), 32'h1);
        applyStimulus(1'b1, 5'd3, 32'h33, 5'd3, 5'd9, 1'b1, 5'd9);
        checkOutput("sb.clr.late", 32'(ifa.busy0), 32'h1);
        idle(5'd3, 5'd9);
        checkOutput("sb.swap.pend", 32'(ifb.pend_cnt), 32'd2);
        checkOutput("sb.swap.r3", 32'(ifa.busy0), 32'h0);
        checkOutput("sb.swap.r9", 32'(ifa.busy1), 32'h1);
        applyStimulus(1'b1, 5'd9, 32'h99, 5'd3, 5'd9, 1'b1, 5'd9);
        idle(5'd3, 5'd9);
        checkOutput("sb.same.pend", 32'(ifa.pend_cnt), 32'd2);
        checkOutput("sb.same.busy", 32'(ifa.busy1), 32'h1);
        checkOutput("sb.same.data", ifb.reg1, 32'h99);
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd4, 5'd9, 1'b1, 5'd4);
        applyStimulus(1'b1, 5'd10, 32'h1, 5'd4, 5'd10, 1'b0, 5'd0);
        idle(5'd4, 5'd10);
        checkOutput("sb.noop.pend", 32'(ifa.pend_cnt), 32'd2);
        checkOutput("sb.noop.r10", 32'(ifa.busy1), 32'h0);

        for (int i = 0; i < 32; i++)
            applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd31, 1'b1, 5'(i));
        idle(5'd0, 5'd31);
        checkOutput("full.b.pend", 32'(ifb.pend_cnt), 32'd32);
        checkOutput("full.a.pend", 32'(ifa.pend_cnt), 32'd31);
        checkOutput("full.a.busy0", 32'(ifa.busy0), 32'h0);
        checkOutput("full.b.busy0", 32'(ifb.busy0), 32'h1);

        applyStimulus(1'b1, 5'd12, 32'hAAAA, 5'd5, 5'd9, 1'b1, 5'd13);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("arst.a.reg0", ifa.reg0, 32'h0);
        checkOutput("arst.b.reg1", ifb.reg1, 32'h0);
        checkOutput("arst.a.busy1", 32'(ifa.busy1), 32'h0);
        checkOutput("arst.b.pend", 32'(ifb.pend_cnt), 32'h0);
        we = 1'b0; bs = 1'b0;
        @(posedge clk);
        #2 reset_n = 1'b1;
        applyStimulus(1'b1, 5'd12, 32'h55, 5'd12, 5'd5, 1'b0, 5'd0);
        idle(5'd12, 5'd5);
        checkOutput("post.a.r12", ifa.reg0, 32'h55);
        checkOutput("post.b.r12", ifb.reg0, 32'h55);
        checkOutput("post.b.r5", ifb.reg1, 32'h0);
        checkOutput("post.b.pend", 32'(ifb.pend_cnt), 32'h0);

        @(posedge clk);
        running = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, register-select width; depth = 2**ADDR_W.
REQ-003 SHALL have parameter ZERO_REG, default 1, meaning register 0 is hardwired to zero and is never busy.
REQ-004 SHALL have parameter BYPASS, default 1, meaning a same-cycle write is forwarded to the read ports.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-006 SHALL have port reset_n, input, 1, reset that is asynchronous and active-low.
REQ-007 SHALL have port reg_write, input, 1, write enable.
REQ-008 SHALL have port w_reg0, input, ADDR_W, write select.
REQ-009 SHALL have port w_data, input, DATA_W, write data.
REQ-010 SHALL have ports r_reg0 and r_reg1, input, ADDR_W each, read selects.
REQ-011 SHALL have ports reg0 and reg1, output, DATA_W each, combinational read data.
REQ-012 SHALL have port busy_set, input, 1, marking a register pending (long-latency producer issued).
REQ-013 SHALL have port busy_reg, input, ADDR_W, the register marked by busy_set.
REQ-014 SHALL have ports busy0 and busy1, output, 1 each, pending status of r_reg0 and r_reg1.
REQ-015 SHALL have port pend_cnt, output, ADDR_W+1, number of registers currently busy.

Function
REQ-016 SHALL write w_data into register w_reg0 on a clk rising edge when reg_write=1.
REQ-017 SHALL ignore writes to register 0 when ZERO_REG=1; reads of register 0 SHALL return 0.
REQ-018 SHALL drive reg0/reg1 combinationally from the selected register, with zero latency.
REQ-019 SHALL, when BYPASS=1, reg_write=1, and w_reg0 equals the read select (excluding register 0 when ZERO_REG=1), drive w_data on that read port in the same cycle.
REQ-020 SHALL, when BYPASS=0, return the pre-write value in the write cycle and the new value from the next cycle.
REQ-021 SHALL keep one busy bit per register: set by busy_set on busy_reg; cleared by reg_write on w_reg0.
REQ-022 SHALL, when busy_set and reg_write target the same register in one cycle, give priority to set; the data is still written and the bit ends at 1.
REQ-023 SHALL leave the busy bit at 1 and pend_cnt unchanged when busy_set targets an already-busy register.
REQ-024 SHALL leave the bit at 0 and pend_cnt unchanged when reg_write targets a non-busy register.
REQ-025 SHALL ignore busy_set to register 0 when ZERO_REG=1.
REQ-026 SHALL update pend_cnt in the same edge as the bits: +1 for a new set only, -1 for an effective clear only, unchanged when both occur on different registers.
REQ-027 SHALL range pend_cnt from 0 to 2**ADDR_W without wrap; pend_cnt SHALL always equal the population count of the busy bits.
REQ-028 SHALL make busy0/busy1 reflect registered busy bits only; a clear in the current cycle SHALL be visible on the next cycle.

Reset
REQ-029 SHALL, on reset_n=0, immediately clear all registers to 0, all busy bits to 0, and pend_cnt to 0, independent of clk.
REQ-030 SHALL abort any in-flight write or set in the cycle reset_n falls; the first update SHALL occur on the first rising edge with reset_n=1.
REQ-031 SHALL show reg0=0, reg1=0, busy0=0, busy1=0, pend_cnt=0 during reset, except for combinational bypass of an active write when BYPASS=1.

Verification
REQ-032 SHALL test: write 0xDEADBEEF to r5, then read r_reg0=5 and r_reg1=0 -> reg0=0xDEADBEEF, reg1=0.
REQ-033 SHALL test: write 0x12345678 to r0 with ZERO_REG=1 -> reg0=0 and busy0=0; repeat with ZERO_REG=0 -> reg0=0x12345678 next cycle.
REQ-034 SHALL test: r7=0x1, then reg_write r7=0x2 with r_reg1=7 in the same cycle -> reg1=0x2 in that cycle for BYPASS=1, and 0x1 then 0x2 for BYPASS=0.
REQ-035 SHALL test: busy_set r3, then busy_set r4 -> pend_cnt=2; write r3 with busy_set r9 in one cycle -> pend_cnt=2, busy r3=0, busy r9=1; write r9 with busy_set r9 -> pend_cnt=2, r9 stays busy.
REQ-036 SHALL test: set all 32 registers busy with ZERO_REG=0 -> pend_cnt=32, no wrap.
REQ-037 SHALL test: assert reset_n=0 mid-sequence between edges -> all outputs 0 at once; first write after release lands correctly.
